// File: rtl/stream_merge.sv
// stream_merge: twelve 32-bit AXI-Stream-style input lanes, each buffered in
// its own DEPTH-word FIFO, merged onto one wide registered output bus.
//
// Ports
//   clk40            single clock, rising edge
//   rstn             asynchronous active-low reset
//   Snn_AXIS_TDATA   lane nn input word (nn = 00..11)
//   Snn_AXIS_TVALID  lane nn input valid
//   Snn_AXIS_TREADY  lane nn ready, decoded from registered state only
//   lane_mask        bit i enables lane i onto the output bus
//   data_out         lane i word on bits [i*32 +: 32], held when not popped
//   valid_out        bit i qualifies lane i of data_out for one cycle
//   align_stall_cnt  saturating count of aligned-mode stall cycles
//
// Handshake: a lane word moves on a rising edge where TVALID and TREADY are
// both high. TREADY never depends on TVALID; it is low while the lane FIFO
// is full (even if that lane pops in the same cycle) and low until the first
// edge after reset release.
//
// ALIGN = 0: every non-empty lane pops each cycle.
// ALIGN = 1: masked lanes pop together only when all of them are non-empty;
//            unmasked lanes always drain (discarded) one word per cycle.
module stream_merge #(
    parameter int DEPTH = 4,
    parameter int ALIGN = 0
) (
    input  logic         clk40,
    input  logic         rstn,
    input  logic [31:0]  S00_AXIS_TDATA,
    input  logic         S00_AXIS_TVALID,
    output logic         S00_AXIS_TREADY,
    input  logic [31:0]  S01_AXIS_TDATA,
    input  logic         S01_AXIS_TVALID,
    output logic         S01_AXIS_TREADY,
    input  logic [31:0]  S02_AXIS_TDATA,
    input  logic         S02_AXIS_TVALID,
    output logic         S02_AXIS_TREADY,
    input  logic [31:0]  S03_AXIS_TDATA,
    input  logic         S03_AXIS_TVALID,
    output logic         S03_AXIS_TREADY,
    input  logic [31:0]  S04_AXIS_TDATA,
    input  logic         S04_AXIS_TVALID,
    output logic         S04_AXIS_TREADY,
    input  logic [31:0]  S05_AXIS_TDATA,
    input  logic         S05_AXIS_TVALID,
    output logic         S05_AXIS_TREADY,
    input  logic [31:0]  S06_AXIS_TDATA,
    input  logic         S06_AXIS_TVALID,
    output logic         S06_AXIS_TREADY,
    input  logic [31:0]  S07_AXIS_TDATA,
    input  logic         S07_AXIS_TVALID,
    output logic         S07_AXIS_TREADY,
    input  logic [31:0]  S08_AXIS_TDATA,
    input  logic         S08_AXIS_TVALID,
    output logic         S08_AXIS_TREADY,
    input  logic [31:0]  S09_AXIS_TDATA,
    input  logic         S09_AXIS_TVALID,
    output logic         S09_AXIS_TREADY,
    input  logic [31:0]  S10_AXIS_TDATA,
    input  logic         S10_AXIS_TVALID,
    output logic         S10_AXIS_TREADY,
    input  logic [31:0]  S11_AXIS_TDATA,
    input  logic         S11_AXIS_TVALID,
    output logic         S11_AXIS_TREADY,
    input  logic [11:0]  lane_mask,
    output logic [383:0] data_out,
    output logic [11:0]  valid_out,
    output logic [15:0]  align_stall_cnt
);

    localparam int LANES   = 12;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam bit ALIGNED = (ALIGN != 0);

    logic [31:0]      lane_data  [LANES];
    logic [LANES-1:0] lane_valid;
    logic [LANES-1:0] lane_ready;

    logic [31:0]      mem    [LANES][DEPTH];
    logic [AW-1:0]    wr_ptr [LANES];
    logic [AW-1:0]    rd_ptr [LANES];
    logic [CW-1:0]    count  [LANES];
    logic             ready_en;

    logic [LANES-1:0] not_empty;
    logic [LANES-1:0] masked_ne;
    logic [LANES-1:0] push;
    logic [LANES-1:0] pop;
    logic             all_ready;
    logic             partial;

    // Flatten the per-lane ports into arrays.
    assign lane_data[0]  = S00_AXIS_TDATA;
    assign lane_data[1]  = S01_AXIS_TDATA;
    assign lane_data[2]  = S02_AXIS_TDATA;
    assign lane_data[3]  = S03_AXIS_TDATA;
    assign lane_data[4]  = S04_AXIS_TDATA;
    assign lane_data[5]  = S05_AXIS_TDATA;
    assign lane_data[6]  = S06_AXIS_TDATA;
    assign lane_data[7]  = S07_AXIS_TDATA;
    assign lane_data[8]  = S08_AXIS_TDATA;
    assign lane_data[9]  = S09_AXIS_TDATA;
    assign lane_data[10] = S10_AXIS_TDATA;
    assign lane_data[11] = S11_AXIS_TDATA;

    assign lane_valid = {S11_AXIS_TVALID, S10_AXIS_TVALID, S09_AXIS_TVALID,
                         S08_AXIS_TVALID, S07_AXIS_TVALID, S06_AXIS_TVALID,
                         S05_AXIS_TVALID, S04_AXIS_TVALID, S03_AXIS_TVALID,
                         S02_AXIS_TVALID, S01_AXIS_TVALID, S00_AXIS_TVALID};

    assign S00_AXIS_TREADY = lane_ready[0];
    assign S01_AXIS_TREADY = lane_ready[1];
    assign S02_AXIS_TREADY = lane_ready[2];
    assign S03_AXIS_TREADY = lane_ready[3];
    assign S04_AXIS_TREADY = lane_ready[4];
    assign S05_AXIS_TREADY = lane_ready[5];
    assign S06_AXIS_TREADY = lane_ready[6];
    assign S07_AXIS_TREADY = lane_ready[7];
    assign S08_AXIS_TREADY = lane_ready[8];
    assign S09_AXIS_TREADY = lane_ready[9];
    assign S10_AXIS_TREADY = lane_ready[10];
    assign S11_AXIS_TREADY = lane_ready[11];

    // Ready and emptiness come only from registered count and ready_en, so
    // there is no combinational path from TVALID to TREADY.
    always_comb begin
        not_empty  = '0;
        lane_ready = '0;
        for (int i = 0; i < LANES; i++) begin
            not_empty[i]  = (count[i] != '0);
            lane_ready[i] = ready_en && (count[i] != CW'(DEPTH));
        end
    end

    assign push      = lane_valid & lane_ready;
    assign masked_ne = not_empty & lane_mask;
    // mask == 0 never counts as "all masked lanes ready".
    assign all_ready = (lane_mask != '0) && (masked_ne == lane_mask);
    assign partial   = (masked_ne != '0) && !all_ready;

    always_comb begin
        pop = '0;
        if (ALIGNED) begin
            // Unmasked lanes drain freely; masked lanes move as one group.
            pop = (not_empty & ~lane_mask) | (all_ready ? lane_mask : '0);
        end else begin
            pop = not_empty;
        end
    end

    // FIFO storage carries no reset; reset empties the lanes via pointers.
    always_ff @(posedge clk40) begin
        for (int i = 0; i < LANES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= lane_data[i];
            end
        end
    end

    always_ff @(posedge clk40 or negedge rstn) begin
        if (!rstn) begin
            ready_en        <= 1'b0;
            data_out        <= '0;
            valid_out       <= '0;
            align_stall_cnt <= '0;
            for (int i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
                // Discarded words (unmasked lanes) leave data_out untouched.
                if (pop[i] && lane_mask[i]) begin
                    data_out[i*32 +: 32] <= mem[i][rd_ptr[i]];
                end
                valid_out[i] <= pop[i] && lane_mask[i];
            end
            if (ALIGNED && partial && (align_stall_cnt != 16'hFFFF)) begin
                align_stall_cnt <= align_stall_cnt + 16'd1;
            end
        end
    end

endmodule
